edge_detector_rnm: RTL and testbench

- Real-number-model (RNM) edge detector for a single analog net `a_i`, declared as wreal/real.
- Digitizes `a_i` with a hysteresis comparator, sampled on the rising edge of `clk`.
- Emits one-cycle pulses on rising and falling transitions of the digitized level.
- Sits at the analog/digital boundary of mixed-signal testbenches and behavioural top levels, turning a modelled analog waveform into clean digital events.

---
 rtl/edge_detector_rnm.sv | 107 ++++++++++
 tb/tb_edge_detector_rnm.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/edge_detector_rnm.sv
// Real-number-model edge detector: hysteresis comparator on a real input with one-cycle edge pulses.
// Optional glitch filter enabled by defining EDGE_DETECTOR_RNM_FILTER_EN.
module edge_detector_rnm #(
  parameter real VTH_HI     = 0.6,
  parameter real VTH_LO     = 0.4,
  parameter int  FILTER_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  real  a_i,
  output logic rising_edge_o,
  output logic falling_edge_o
);

  localparam bit SINGLE_THR = (VTH_LO >= VTH_HI);

  generate
    if (SINGLE_THR) begin : g_thr_chk
      $error("edge_detector_rnm: VTH_LO >= VTH_HI, using single threshold VTH_HI");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 16) begin : g_len_chk
      $error("edge_detector_rnm: FILTER_LEN out of range 1..16");
    end
  endgenerate

  logic        r_lvl;
  logic        r_primed;
  logic [10:0] w_exp;
  logic        w_invalid;
  logic        w_lvl_ref;
  logic        w_d;

  // All-ones exponent marks NaN or +/-infinity.
  assign w_exp     = 11'($realtobits(a_i) >> 52);
  assign w_invalid = &w_exp;

  // Hysteresis comparator; the unprimed level is treated as 0.
  always_comb begin
    w_lvl_ref = r_primed ? r_lvl : 1'b0;
    w_d       = w_lvl_ref;
    if (!w_invalid) begin
      if (SINGLE_THR || !w_lvl_ref) begin
        w_d = (a_i >= VTH_HI);
      end else begin
        w_d = !(a_i <= VTH_LO);
      end
    end
  end

`ifdef EDGE_DETECTOR_RNM_FILTER_EN
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lvl          <= 1'b0;
      r_primed       <= 1'b0;
      r_cnt          <= '0;
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
    end else if (!r_primed) begin
      r_lvl          <= w_d;
      r_primed       <= 1'b1;
      r_cnt          <= '0;
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
    end else begin
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
      // Level flips only once disagreement has persisted FILTER_LEN samples.
      if (w_d != r_lvl) begin
        if (r_cnt >= CNT_LAST) begin
          r_lvl          <= w_d;
          r_cnt          <= '0;
          rising_edge_o  <= w_d;
          falling_edge_o <= ~w_d;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lvl          <= 1'b0;
      r_primed       <= 1'b0;
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
    end else if (!r_primed) begin
      r_lvl          <= w_d;
      r_primed       <= 1'b1;
      rising_edge_o  <= 1'b0;
      falling_edge_o <= 1'b0;
    end else begin
      rising_edge_o  <= w_d & ~r_lvl;
      falling_edge_o <= ~w_d & r_lvl;
      r_lvl          <= w_d;
    end
  end
`endif

endmodule

// File: tb/tb_edge_detector_rnm.sv
// Self-checking bench for edge_detector_rnm: directed test-plan sequences plus random stimulus vs a reference model.
module tb_edge_detector_rnm;

  localparam real HI = 0.6;
  localparam real LO = 0.4;
  localparam int  FLEN = 2;

  logic clk = 1'b0;
  logic reset;
  real  a_i;
  logic rising_edge_o;
  logic falling_edge_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit m_lvl    = 1'b0;
  bit m_primed = 1'b0;
  bit m_rise   = 1'b0;
  bit m_fall   = 1'b0;
  int m_streak = 0;

  real vals[10];

  edge_detector_rnm #(.VTH_HI(HI), .VTH_LO(LO), .FILTER_LEN(FLEN)) dut (
    .clk           (clk),
    .reset         (reset),
    .a_i           (a_i),
    .rising_edge_o (rising_edge_o),
    .falling_edge_o(falling_edge_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  function automatic bit is_valid(input real v);
    return (v == v) && (v < 1.0e308) && (v > -1.0e308);
  endfunction

  // Level the sample asks for: above HI means high, below LO means low, otherwise unchanged.
  function automatic bit target(input real v, input bit cur);
    if (!is_valid(v)) return cur;
    if (v >= HI) return 1'b1;
    if (v <= LO) return 1'b0;
    return cur;
  endfunction

  task automatic model(input real v, input bit rst);
    bit t;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!rst) begin
      m_lvl = 1'b0; m_primed = 1'b0; m_streak = 0;
    end else if (!m_primed) begin
      m_lvl = target(v, 1'b0); m_primed = 1'b1; m_streak = 0;
    end else begin
      t = target(v, m_lvl);
`ifdef EDGE_DETECTOR_RNM_FILTER_EN
      if (t != m_lvl) m_streak++;
      else m_streak = 0;
      if (m_streak >= FLEN) begin
        m_rise = t; m_fall = !t; m_lvl = t; m_streak = 0;
      end
`else
      m_rise = t && !m_lvl;
      m_fall = !t && m_lvl;
      m_lvl  = t;
`endif
    end
  endtask

  // Drive one sample, let the DUT clock it, then compare; a glitch follows the edge.
  task automatic step(input real v, input logic rst);
    @(negedge clk);
    a_i   = v;
    reset = rst;
    @(posedge clk);
    #1;
    model(v, rst);
    check("rise", rising_edge_o, m_rise);
    check("fall", falling_edge_o, m_fall);
    check("excl", rising_edge_o & falling_edge_o, 1'b0);
    a_i = (v < 0.5) ? 1.0 : 0.0;
  endtask

  initial begin
    real nan_v;
    real inf_v;
    nan_v = $bitstoreal(64'h7FF8_0000_0000_0000);
    inf_v = $bitstoreal(64'h7FF0_0000_0000_0000);
    vals = '{0.0, 0.3, 0.4, 0.45, 0.5, 0.6, 0.65, 1.0, 0.0, 1.0};
    reset = 1'b0;
    a_i   = 1.0;

    // Reset hold then prime high: no pulses
    step(1.0, 1'b0);
    step(1.0, 1'b0);
    step(1.0, 1'b1);
    step(1.0, 1'b1);

    // Square wave
    for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 0.0 : 1.0, 1'b1);

    // Hysteresis ramp
    step(0.0, 1'b1);
    step(0.0, 1'b1);
    step(0.5, 1'b1);
    step(0.65, 1'b1);
    step(0.65, 1'b1);
    step(0.5, 1'b1);
    step(0.45, 1'b1);
    step(0.35, 1'b1);
    step(0.35, 1'b1);
    step(0.35, 1'b1);

    // Invalid input while high
    step(1.0, 1'b1);
    step(1.0, 1'b1);
    step(nan_v, 1'b1);
    step(inf_v, 1'b1);
    step(nan_v, 1'b1);
    step(0.0, 1'b1);
    step(0.0, 1'b1);
    step(0.0, 1'b1);

    // Reset mid-pulse, re-prime high
    step(1.0, 1'b1);
    step(1.0, 1'b1);
    step(1.0, 1'b0);
    step(1.0, 1'b1);
    step(1.0, 1'b1);

    // Spike then held high (filter behaviour visible in filtered build)
    step(0.0, 1'b1);
    step(0.0, 1'b1);
    step(1.0, 1'b1);
    step(0.0, 1'b1);
    step(1.0, 1'b1);
    step(1.0, 1'b1);
    step(1.0, 1'b1);

    // Random stimulus including invalid samples and occasional resets
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      real v;
      r = $urandom_range(0, 11);
      if (r < 10) v = vals[r];
      else if (r == 10) v = nan_v;
      else v = inf_v;
      step(v, ($urandom_range(0, 39) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
